// File: rtl/add_rr_arbiter_if.sv
// Requester and adder-side handshake bundle for add_rr_arbiter.
// master = arbiter view, slave = environment (requesters + adder) view.
interface add_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_vld;
  logic [NREQ-1:0]   req_rdy;
  logic [W-1:0]      resp_data;
  logic [NREQ-1:0]   resp_vld;
  logic [NREQ-1:0]   resp_rdy;
  logic [W-1:0]      add_in0;
  logic              add_in0_vld;
  logic              add_in0_rdy;
  logic [W-1:0]      add_in1;
  logic              add_in1_vld;
  logic              add_in1_rdy;
  logic [W-1:0]      add_out0;
  logic              add_out0_vld;
  logic              add_out0_rdy;
  logic              err;

  modport master (
    input  req_a, req_b, req_vld, resp_rdy,
    input  add_in0_rdy, add_in1_rdy, add_out0, add_out0_vld,
    output req_rdy, resp_data, resp_vld,
    output add_in0, add_in0_vld, add_in1, add_in1_vld, add_out0_rdy, err
  );

  modport slave (
    output req_a, req_b, req_vld, resp_rdy,
    output add_in0_rdy, add_in1_rdy, add_out0, add_out0_vld,
    input  req_rdy, resp_data, resp_vld,
    input  add_in0, add_in0_vld, add_in1, add_in1_vld, add_out0_rdy, err
  );
endinterface

// File: rtl/add_rr_arbiter.sv
// Round-robin sharing of one pipelined valid/ready adder among NREQ requesters.
// Winner indices go into an in-order tag FIFO that steers results back.
//
//   state | meaning
//   IDLE  | look for a request; grant only while the tag FIFO has room
//   ISSUE | present the granted operands until both adder channels accept
module add_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  add_rr_arbiter_if.master bus
);
  localparam int TW = $clog2(NREQ);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   rr_ptr, rr_nxt;
  logic [TW-1:0]   grant, grant_nxt;
  logic            sent0, sent1, sent0_nxt, sent1_nxt;
  logic            acc0, acc1;
  logic            found;
  logic [TW-1:0]   pick;
  logic            push, pop, empty;
  logic [TW-1:0]   fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   head;
  logic            err_q;
  logic [NREQ-1:0] req_rdy_c;
  logic [NREQ-1:0] resp_vld_c;
  logic            in0_vld_c, in1_vld_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin pick: first valid requester after the last winner.
  always_comb begin
    logic [TW-1:0] idx;
    idx   = '0;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = TW'((int'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_vld[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state and handshake outputs; a channel counts as accepted in the cycle its rdy is seen.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    sent0_nxt = sent0;
    sent1_nxt = sent1;
    in0_vld_c = 1'b0;
    in1_vld_c = 1'b0;
    req_rdy_c = '0;
    push      = 1'b0;
    acc0      = 1'b0;
    acc1      = 1'b0;
    case (state)
      IDLE: begin
        if (found && (count < CW'(DEPTH))) begin
          grant_nxt = pick;
          rr_nxt    = pick;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        in0_vld_c = ~sent0;
        in1_vld_c = ~sent1;
        acc0      = sent0 | bus.add_in0_rdy;
        acc1      = sent1 | bus.add_in1_rdy;
        if (acc0 && acc1) begin
          req_rdy_c[grant] = 1'b1;
          push             = 1'b1;
          sent0_nxt        = 1'b0;
          sent1_nxt        = 1'b0;
          state_nxt        = IDLE;
        end else begin
          sent0_nxt = acc0;
          sent1_nxt = acc1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= TW'(NREQ - 1);
      grant  <= '0;
      sent0  <= 1'b0;
      sent1  <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      grant  <= grant_nxt;
      sent0  <= sent0_nxt;
      sent1  <= sent1_nxt;
    end
  end

  // Tag FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= grant;
  end

  // Sticky error: adder produced a result nobody is waiting for.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          err_q <= 1'b0;
    else if (bus.add_out0_vld && empty) err_q <= 1'b1;
  end

  assign head  = fifo_mem[rd_ptr];
  assign empty = (count == '0);

  // Steer the result valid to the requester at the FIFO head.
  always_comb begin
    resp_vld_c = '0;
    if (bus.add_out0_vld && !empty) resp_vld_c[head] = 1'b1;
  end

  assign pop              = bus.add_out0_vld & bus.add_out0_rdy;
  assign bus.add_out0_rdy = ~empty & bus.resp_rdy[head];
  assign bus.resp_vld     = resp_vld_c;
  assign bus.resp_data    = bus.add_out0;
  assign bus.req_rdy      = req_rdy_c;
  assign bus.add_in0      = bus.req_a[int'(grant)*W +: W];
  assign bus.add_in1      = bus.req_b[int'(grant)*W +: W];
  assign bus.add_in0_vld  = in0_vld_c;
  assign bus.add_in1_vld  = in1_vld_c;
  assign bus.err          = err_q;
endmodule
